// File: rtl/aemb2_xsched_pkg.sv
// AEMB2 execution scheduler shared definitions.
// Opcode classes, writeback select codes and the EX slot record.
package aemb2_xsched_pkg;

    localparam logic [2:0] MUX_ALU = 3'd0;
    localparam logic [2:0] MUX_MUL = 3'd1;
    localparam logic [2:0] MUX_BSF = 3'd2;
    localparam logic [2:0] MUX_SFR = 3'd3;
    localparam logic [2:0] MUX_LDD = 3'd4;

    localparam logic [5:0] OPC_MUL = 6'b010000;
    localparam logic [5:0] OPC_BSF = 6'b010001;
    localparam logic [5:0] OPC_MFS = 6'b100101;
    localparam logic [5:0] OPC_NB0 = 6'b100111;
    localparam logic [5:0] OPC_NB1 = 6'b101111;
    localparam logic [5:0] OPC_NB2 = 6'b101101;

    typedef enum logic {
        RUN,
        MEMW
    } xs_state_t;

    typedef struct packed {
        logic       vld;
        logic [5:0] opc;
        logic [4:0] rd;
        logic       ph;
    } ex_slot_t;

    function automatic logic is_ld(input logic [5:0] opc);
        return (opc[5:4] == 2'b11) && !opc[2];
    endfunction

    function automatic logic is_st(input logic [5:0] opc);
        return (opc[5:4] == 2'b11) && opc[2];
    endfunction

    function automatic logic is_mem(input logic [5:0] opc);
        return opc[5:4] == 2'b11;
    endfunction

    function automatic logic is_nowb(input logic [5:0] opc);
        return is_st(opc) || opc == OPC_NB0 ||
               opc == OPC_NB1 || opc == OPC_NB2;
    endfunction

    // Ops whose result is not ready for the very next instruction.
    function automatic logic is_late(
        input logic [5:0] opc,
        input logic       mul,
        input logic       bsf
    );
        return is_ld(opc) || (mul && opc == OPC_MUL) ||
               (bsf && opc == OPC_BSF);
    endfunction

    function automatic logic [2:0] mux_sel(
        input logic [5:0] opc,
        input logic       mul,
        input logic       bsf
    );
        logic [2:0] r;
        unique case (1'b1)
            is_ld(opc):              r = MUX_LDD;
            opc == OPC_MFS:          r = MUX_SFR;
            mul && opc == OPC_MUL:   r = MUX_MUL;
            bsf && opc == OPC_BSF:   r = MUX_BSF;
            default:                 r = MUX_ALU;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aemb2_xsched_xhzd.sv
// AEMB2 read-after-write hazard comparator.
// Flags an OF instruction that reads a late result still in EX.
module aemb2_xsched_xhzd
    import aemb2_xsched_pkg::*;
#(
    parameter int AEMB_HTX = 1,
    parameter int AEMB_MUL = 1,
    parameter int AEMB_BSF = 1
) (
    input  logic       run,
    input  ex_slot_t   ex,
    input  logic       gpha,
    input  logic       iss_stb,
    input  logic       rb_use,
    input  logic [4:0] ra_of,
    input  logic [4:0] rb_of,
    output logic       hzd
);

    localparam logic ST = (AEMB_HTX == 0);
    localparam logic HM = (AEMB_MUL != 0);
    localparam logic HB = (AEMB_BSF != 0);

    logic late;
    logic hit_a;
    logic hit_b;

    assign late  = ex.vld && is_late(ex.opc, HM, HB) &&
                   (ex.rd != 5'd0) && (ex.ph == gpha);
    assign hit_a = (ra_of == ex.rd);
    assign hit_b = rb_use && (rb_of == ex.rd);
    assign hzd   = ST && run && late && iss_stb &&
                   (hit_a || hit_b);

endmodule

// File: rtl/aemb2_xsched.sv
// AEMB2 execution scheduler: pipe advance, bus stall,
// hazard bubbles and MX-stage writeback control.
module aemb2_xsched
    import aemb2_xsched_pkg::*;
#(
    parameter int AEMB_HTX = 1,
    parameter int AEMB_MUL = 1,
    parameter int AEMB_BSF = 1
) (
    input  logic       gclk,
    input  logic       grst,
    input  logic       iss_stb,
    input  logic [5:0] opc_of,
    input  logic [4:0] rd_of,
    input  logic [4:0] ra_of,
    input  logic [4:0] rb_of,
    input  logic       dwb_ack,
    output logic       dena,
    output logic       gpha,
    output logic       hzd,
    output logic       dwb_stb,
    output logic [2:0] mux_mx,
    output logic [4:0] rd_mx,
    output logic       wre_mx
);

    localparam logic MT = (AEMB_HTX != 0);
    localparam logic HM = (AEMB_MUL != 0);
    localparam logic HB = (AEMB_BSF != 0);

    xs_state_t state;
    xs_state_t nxt;
    logic      nxt_stb;
    ex_slot_t  ex;
    logic      run;
    logic      cap;
    logic      cap_mem;

    assign run     = (state == RUN);
    assign dena    = grst && (run || (dwb_ack && dwb_stb));
    assign cap     = iss_stb && !hzd;
    assign cap_mem = cap && is_mem(opc_of);

    aemb2_xsched_xhzd #(
        .AEMB_HTX (AEMB_HTX),
        .AEMB_MUL (AEMB_MUL),
        .AEMB_BSF (AEMB_BSF)
    ) u_xhzd (
        .run     (run),
        .ex      (ex),
        .gpha    (gpha),
        .iss_stb (iss_stb),
        .rb_use  (!opc_of[3]),
        .ra_of   (ra_of),
        .rb_of   (rb_of),
        .hzd     (hzd)
    );

    // A memory op accepted on an ack edge waits one strobe-low cycle.
    always_comb begin
        nxt     = state;
        nxt_stb = dwb_stb;
        unique case (state)
            RUN: begin
                nxt_stb = cap_mem;
                nxt     = cap_mem ? MEMW : RUN;
            end
            MEMW: begin
                if (!dwb_stb) begin
                    nxt_stb = 1'b1;
                end else if (dwb_ack) begin
                    nxt_stb = 1'b0;
                    nxt     = cap_mem ? MEMW : RUN;
                end
            end
        endcase
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state   <= RUN;
            dwb_stb <= 1'b0;
        end else begin
            state   <= nxt;
            dwb_stb <= nxt_stb;
        end
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            ex   <= '0;
            gpha <= 1'b0;
        end else if (dena) begin
            ex.vld <= cap;
            ex.opc <= opc_of;
            ex.rd  <= rd_of;
            ex.ph  <= gpha;
            gpha   <= MT && !gpha;
        end
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            mux_mx <= MUX_ALU;
            rd_mx  <= 5'd0;
            wre_mx <= 1'b0;
        end else if (dena) begin
            mux_mx <= mux_sel(ex.opc, HM, HB);
            rd_mx  <= ex.rd;
            wre_mx <= ex.vld && (ex.rd != 5'd0) &&
                      !is_nowb(ex.opc);
        end
    end

endmodule
